// File: rtl/ccip_mmio_ring_pkg.sv
// ccip_mmio_ring_pkg
//   Shared types for the MMIO/ring CPU-NIC interface: the minimal CCI-P
//   structures this block touches, the RPC payload types, the ring FSM
//   states, the skid FIFO entry and the ring slot address helper.
package ccip_mmio_ring_pkg;

  // MMIO addresses count 4-byte words, so one 64B cache line spans 16 words.
  localparam int CL_SIZE_WORDS = 16;
  localparam int CL_SHIFT      = $clog2(CL_SIZE_WORDS);
  // Widest flow id the skid FIFO entry can carry.
  localparam int MAX_FLOW_W    = 8;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [511:0] RpcPckt;
  typedef logic [127:0] RpcIf;

  typedef enum logic [1:0] {
    eVC_VA  = 2'd0,
    eVC_VL0 = 2'd1,
    eVC_VH0 = 2'd2,
    eVC_VH1 = 2'd3
  } t_ccip_vc;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2
  } t_ccip_c1_req;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic [8:0]     tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_clData        data;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic         sop;
    t_ccip_c1_req req_type;
    t_ccip_clAddr address;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef enum logic [1:0] {
    S_UNINIT = 2'd0,
    S_CLEAR  = 2'd1,
    S_READY  = 2'd2
  } t_ring_state;

  typedef struct packed {
    RpcIf                  rpc;
    logic [MAX_FLOW_W-1:0] flow;
  } t_skid_entry;

  // Each flow owns 2^lring_depth consecutive cache lines starting at base.
  function automatic t_ccip_clAddr slot_addr(input t_ccip_clAddr base,
                                             input logic [31:0]  flow,
                                             input logic [31:0]  tail,
                                             input int unsigned  lring_depth);
    t_ccip_clAddr flow_off;
    flow_off = t_ccip_clAddr'(flow) << lring_depth;
    return base + flow_off + t_ccip_clAddr'(tail);
  endfunction

endpackage

// File: rtl/ccip_mmio_skid_fifo.sv
// ccip_mmio_skid_fifo
//   Synchronous FIFO of 2^LDEPTH entries used to absorb c1 backpressure.
//   Ports: clk/reset (sync, active-high), flush_i (empties the FIFO),
//   push_i/wdata_i (write; ignored when full), pop_i (advance head; ignored
//   when empty), rdata_o (head entry), full_o, empty_o, count_o, free_o.
//   Push and pop in the same cycle leave the count unchanged.
module ccip_mmio_skid_fifo #(
  parameter int LDEPTH = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              pop_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LDEPTH:0]   count_o,
  output logic [LDEPTH:0]   free_o
);

  localparam int DEPTH = 1 << LDEPTH;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [LDEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LDEPTH:0]   count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (LDEPTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign free_o  = (LDEPTH+1)'(DEPTH) - count_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + LDEPTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + LDEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (LDEPTH+1)'(1);
        2'b01:   count_q <= count_q - (LDEPTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ccip_mmio_ring.sv
// ccip_mmio_ring
//   CPU-NIC: MMIO writes inside the window at tx_base_addr are decoded into
//   a flow id (one cache line of window per flow) and forwarded as rpc_out
//   two cycles later. NIC-CPU: rpc_in responses pass through a skid FIFO and
//   are written to per-flow host rings of 2^LRING_DEPTH lines at
//   rx_base_addr, each flow advancing its own wrapping tail pointer.
//   A clear FSM (S_UNINIT/S_CLEAR/S_READY, visible on dbg_state) zeroes the
//   tails on initialize; the datapaths run only in S_READY with start=1.
//   Handshake: rpc_in_valid is a one-cycle push; upstream should hold off
//   while ccip_tx_ready=0 (a push into a full FIFO is dropped and counted).
//   Statistics (stat_rx_drop, stat_tx_ovf) exist only when
//   CCIP_MMIO_RING_STATS_EN is defined; otherwise they read 0.
import ccip_mmio_ring_pkg::*;

module ccip_mmio_ring #(
  parameter int           NIC_ID            = 0,
  parameter int           LMAX_NUM_OF_FLOWS = 1,
  parameter int           LRING_DEPTH       = 2,
  parameter int           LSKID_DEPTH       = 4,
  parameter int           SKID_AFULL_SLACK  = 2,
  parameter t_ccip_vc     BACKWARD_VC       = eVC_VH0,
  parameter t_ccip_c1_req BACKWARD_WR_TYPE  = eREQ_WRLINE_I
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_ccip_clAddr                 rx_base_addr,
  input  t_ccip_mmioAddr               tx_base_addr,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic                         start,
  input  logic                         initialize,
  output logic                         initialized,
  input  logic                         sRx_c0TxAlmFull,
  input  logic                         sRx_c1TxAlmFull,
  input  logic                         sRx_c0MMIOWrValid,
  input  t_if_ccip_c0_Rx               sRx_c0,
  output t_if_ccip_c1_Tx               sTx_c1,
  output RpcPckt                       rpc_out,
  output logic                         rpc_out_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic                         ccip_tx_ready,
  input  RpcIf                         rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
  output logic [31:0]                  stat_rx_drop,
  output logic [31:0]                  stat_tx_ovf,
  output t_ring_state                  dbg_state
);

  localparam int          FW        = LMAX_NUM_OF_FLOWS;
  localparam int          NFLOWS    = 1 << FW;
  localparam logic [31:0] WIN_WORDS = 32'(NFLOWS * CL_SIZE_WORDS);

  // ---------------- clear FSM ----------------
  t_ring_state   state_q, state_d;
  logic [FW-1:0] clr_idx_q, clr_idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_UNINIT;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      S_UNINIT: if (initialize) begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
      end
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + FW'(1);
        if (clr_idx_q == FW'(NFLOWS - 1)) state_d = S_READY;
      end
      S_READY: if (initialize) begin
        state_d   = S_CLEAR;
        clr_idx_d = '0;
      end
      default: state_d = S_UNINIT;
    endcase
  end

  assign initialized = (state_q == S_READY);
  assign dbg_state   = state_q;

  // An initialize seen in S_READY already starts the teardown, so nothing
  // new is accepted on that cycle.
  logic accept;
  assign accept = (state_q == S_READY) && start && !initialize;

  // ---------------- CPU-NIC (MMIO decode) ----------------
  logic [16:0]   off;
  logic          hit;
  logic [FW-1:0] flow_dec;

  // The extra top bit turns addresses below the window into a negative offset.
  assign off      = {1'b0, sRx_c0.hdr.address} - {1'b0, tx_base_addr};
  assign hit      = !off[16] && ({16'd0, off[15:0]} < WIN_WORDS);
  assign flow_dec = off[FW+CL_SHIFT-1:CL_SHIFT];

  logic          s1_valid_q, s1_hit_q;
  logic [FW-1:0] s1_flow_q;
  RpcPckt        s1_data_q;
  logic          rpc_valid_q;
  logic [FW-1:0] rpc_flow_q;
  RpcPckt        rpc_data_q;
  logic          flow_ok, rx_drop_evt;

  // number_of_flows is only FW bits wide and cannot express 2^FW, so 0
  // (a meaningless count) selects every flow.
  assign flow_ok     = (number_of_flows == '0) || (s1_flow_q < number_of_flows);
  assign rx_drop_evt = s1_valid_q && !(s1_hit_q && flow_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      rpc_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= accept && sRx_c0MMIOWrValid;
      rpc_valid_q <= s1_valid_q && s1_hit_q && flow_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && sRx_c0MMIOWrValid) begin
      s1_hit_q  <= hit;
      s1_flow_q <= flow_dec;
      s1_data_q <= sRx_c0.data;
    end
    if (s1_valid_q) begin
      rpc_flow_q <= s1_flow_q;
      rpc_data_q <= s1_data_q;
    end
  end

  assign rpc_out         = rpc_data_q;
  assign rpc_out_valid   = rpc_valid_q;
  assign rpc_flow_id_out = rpc_flow_q;

  // ---------------- NIC-CPU (skid FIFO + rings) ----------------
  t_skid_entry          fifo_wdata, fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_flush, push, pop, tx_ovf_evt;
  logic [LSKID_DEPTH:0] fifo_count, fifo_free;
  logic [FW-1:0]        head_flow;

  assign push       = accept && rpc_in_valid;
  assign pop        = accept && !fifo_empty && !sRx_c1TxAlmFull;
  assign fifo_flush = (state_q != S_READY) || initialize;
  assign tx_ovf_evt = push && fifo_full;
  assign fifo_wdata = '{rpc: rpc_in, flow: MAX_FLOW_W'(rpc_flow_id_in)};
  assign head_flow  = fifo_rdata.flow[FW-1:0];

  ccip_mmio_skid_fifo #(
    .LDEPTH (LSKID_DEPTH),
    .WIDTH  ($bits(t_skid_entry))
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (fifo_flush),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .free_o  (fifo_free)
  );

  logic [LRING_DEPTH-1:0] tail_q [NFLOWS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NFLOWS; i++) tail_q[i] <= '0;
    end else if (state_q == S_CLEAR) begin
      tail_q[clr_idx_q] <= '0;
    end else if (pop) begin
      tail_q[head_flow] <= tail_q[head_flow] + LRING_DEPTH'(1);
    end
  end

  logic         c1_valid_q;
  t_ccip_clAddr c1_addr_q;
  t_ccip_clData c1_data_q;

  always_ff @(posedge clk) begin
    if (reset) c1_valid_q <= 1'b0;
    else       c1_valid_q <= pop;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      c1_addr_q <= slot_addr(rx_base_addr, 32'(head_flow), 32'(tail_q[head_flow]),
                             LRING_DEPTH);
      c1_data_q <= t_ccip_clData'(fifo_rdata.rpc);
    end
  end

  assign sTx_c1 = '{hdr: '{vc_sel: BACKWARD_VC, sop: 1'b1, req_type: BACKWARD_WR_TYPE,
                           address: c1_addr_q},
                    data: c1_data_q, valid: c1_valid_q};

  // Computed from the pre-edge free count; the slack covers the extra
  // push that can land while the deassertion is still a cycle away.
  logic tx_ready_q;
  always_ff @(posedge clk) begin
    if (reset) tx_ready_q <= 1'b0;
    else       tx_ready_q <= (state_d == S_READY) && (int'(fifo_free) > SKID_AFULL_SLACK);
  end
  assign ccip_tx_ready = tx_ready_q;

  // ---------------- statistics ----------------
`ifdef CCIP_MMIO_RING_STATS_EN
  logic [31:0] rx_drop_q, tx_ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_drop_q <= '0;
      tx_ovf_q  <= '0;
    end else begin
      if (rx_drop_evt && (rx_drop_q != '1)) rx_drop_q <= rx_drop_q + 32'd1;
      if (tx_ovf_evt && (tx_ovf_q != '1))   tx_ovf_q  <= tx_ovf_q + 32'd1;
    end
  end
  assign stat_rx_drop = rx_drop_q;
  assign stat_tx_ovf  = tx_ovf_q;
`else
  logic unused_stat_evts;
  assign unused_stat_evts = rx_drop_evt ^ tx_ovf_evt;
  assign stat_rx_drop = '0;
  assign stat_tx_ovf  = '0;
`endif

  logic unused_misc;
  assign unused_misc = ^{sRx_c0TxAlmFull, sRx_c0.hdr.length, sRx_c0.hdr.tid,
                         fifo_count, fifo_rdata.flow, 32'(NIC_ID)};

endmodule

// File: tb/tb_ccip_mmio_ring.sv
module tb_ccip_mmio_ring;
  import ccip_mmio_ring_pkg::*;

  localparam int L     = 2;
  localparam int LR    = 2;
  localparam int LS    = 4;
  localparam int SLACK = 2;

`ifdef CCIP_MMIO_RING_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  t_ccip_clAddr   rx_base_addr;
  t_ccip_mmioAddr tx_base_addr;
  logic [L-1:0]   number_of_flows;
  logic           start, initialize, initialized;
  logic           sRx_c0TxAlmFull, sRx_c1TxAlmFull, sRx_c0MMIOWrValid;
  t_if_ccip_c0_Rx sRx_c0;
  t_if_ccip_c1_Tx sTx_c1;
  RpcPckt         rpc_out;
  logic           rpc_out_valid;
  logic [L-1:0]   rpc_flow_id_out;
  logic           ccip_tx_ready;
  RpcIf           rpc_in;
  logic           rpc_in_valid;
  logic [L-1:0]   rpc_flow_id_in;
  logic [31:0]    stat_rx_drop, stat_tx_ovf;
  t_ring_state    dbg_state;

  ccip_mmio_ring #(
    .NIC_ID(0), .LMAX_NUM_OF_FLOWS(L), .LRING_DEPTH(LR), .LSKID_DEPTH(LS),
    .SKID_AFULL_SLACK(SLACK), .BACKWARD_VC(eVC_VH0), .BACKWARD_WR_TYPE(eREQ_WRLINE_I)
  ) dut (
    .clk(clk), .reset(reset), .rx_base_addr(rx_base_addr), .tx_base_addr(tx_base_addr),
    .number_of_flows(number_of_flows), .start(start), .initialize(initialize),
    .initialized(initialized), .sRx_c0TxAlmFull(sRx_c0TxAlmFull),
    .sRx_c1TxAlmFull(sRx_c1TxAlmFull), .sRx_c0MMIOWrValid(sRx_c0MMIOWrValid),
    .sRx_c0(sRx_c0), .sTx_c1(sTx_c1), .rpc_out(rpc_out), .rpc_out_valid(rpc_out_valid),
    .rpc_flow_id_out(rpc_flow_id_out), .ccip_tx_ready(ccip_tx_ready), .rpc_in(rpc_in),
    .rpc_in_valid(rpc_in_valid), .rpc_flow_id_in(rpc_flow_id_in),
    .stat_rx_drop(stat_rx_drop), .stat_tx_ovf(stat_tx_ovf), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int c1_seen  = 0;
  int rpc_seen = 0;
  logic [169:0] exp_q [$];      // c1 writes: {address, response data}
  logic [513:0] exp_rpc_q [$];  // requests:  {flow, payload}
  logic [LR-1:0] model_tail [1<<L];

  task automatic chk(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [169:0] e;
    logic [513:0] r;
    logic [6:0]   exp_hdr;
    if (!reset && sTx_c1.valid) begin
      c1_seen++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL c1_unexpected got addr=%0h exp=no write", sTx_c1.hdr.address);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        exp_hdr = {eVC_VH0, 1'b1, eREQ_WRLINE_I};
        chk("c1_addr", 576'(sTx_c1.hdr.address), 576'(e[169:128]));
        chk("c1_data", 576'(sTx_c1.data), 576'(e[127:0]));
        chk("c1_hdr", 576'({sTx_c1.hdr.vc_sel, sTx_c1.hdr.sop, sTx_c1.hdr.req_type}),
            576'(exp_hdr));
      end
    end
    if (!reset && rpc_out_valid) begin
      rpc_seen++;
      checks++;
      assert (exp_rpc_q.size() != 0) else begin
        failures++;
        $error("FAIL rpc_unexpected got flow=%0d exp=no request", rpc_flow_id_out);
      end
      if (exp_rpc_q.size() != 0) begin
        r = exp_rpc_q.pop_front();
        chk("rpc_out", 576'({rpc_flow_id_out, rpc_out}), 576'(r));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {32'($urandom_range(32'hFFFF_FFFF, 0)), 32'($urandom_range(32'hFFFF_FFFF, 0)),
            32'($urandom_range(32'hFFFF_FFFF, 0)), 32'($urandom_range(32'hFFFF_FFFF, 0))};
  endfunction

  function automatic logic [31:0] exp_stat(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  task automatic rpc_push(input int flow, input logic [127:0] data, input bit expect_wr);
    logic [41:0] addr;
    rpc_in         = data;
    rpc_flow_id_in = L'(flow);
    rpc_in_valid   = 1'b1;
    if (expect_wr) begin
      addr = 42'h1000 + 42'(flow * (1 << LR)) + 42'(model_tail[flow]);
      exp_q.push_back({addr, data});
      model_tail[flow] = model_tail[flow] + LR'(1);
    end
    tick();
    rpc_in_valid = 1'b0;
  endtask

  task automatic mmio_write(input logic [15:0] addr, input logic [511:0] data,
                            input bit expect_req, input int flow);
    sRx_c0.hdr.address = addr;
    sRx_c0.data        = data;
    sRx_c0MMIOWrValid  = 1'b1;
    if (expect_req) exp_rpc_q.push_back({L'(flow), data});
    tick();
    sRx_c0MMIOWrValid = 1'b0;
  endtask

  // initialize is sampled on the edge inside the first tick; initialized
  // must rise 2^L edges after that one (2^L + 1 cycles after the pulse).
  task automatic run_init(input string tag);
    int n;
    initialize = 1'b1;
    tick();
    initialize = 1'b0;
    chk({tag, "_clearing"}, 576'(initialized), 576'(0));
    n = 0;
    while (!initialized && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 576'(n), 576'(1 << L));
    for (int i = 0; i < (1 << L); i++) model_tail[i] = '0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_rpc_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_drained"}, 576'(exp_q.size() + exp_rpc_q.size()), 576'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen0;
    logic [511:0] d;
    reset = 1'b1; start = 1'b0; initialize = 1'b0;
    sRx_c0TxAlmFull = 1'b0; sRx_c1TxAlmFull = 1'b0; sRx_c0MMIOWrValid = 1'b0;
    sRx_c0 = '0; rpc_in = '0; rpc_in_valid = 1'b0; rpc_flow_id_in = '0;
    rx_base_addr = 42'h1000; tx_base_addr = 16'h100; number_of_flows = '0;
    for (int i = 0; i < (1 << L); i++) model_tail[i] = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_initialized", 576'(initialized), 576'(0));
    chk("rst_rpc_valid", 576'(rpc_out_valid), 576'(0));
    chk("rst_c1_valid", 576'(sTx_c1.valid), 576'(0));
    chk("rst_tx_ready", 576'(ccip_tx_ready), 576'(0));
    chk("rst_stats", 576'({stat_rx_drop, stat_tx_ovf}), 576'(0));
    chk("rst_state", 576'(dbg_state), 576'(S_UNINIT));
    reset = 1'b0;
    start = 1'b1;
    tick();

    // First initialize from reset
    run_init("init1");
    tick();
    chk("ready_after_init", 576'(ccip_tx_ready), 576'(1));

    // MMIO decode: 0x130 -> flow 3, arrives two cycles after the write
    d = {4{rand128()}};
    mmio_write(16'h130, d, 1'b1, 3);
    chk("rpc_lat_n1", 576'(rpc_out_valid), 576'(0));
    tick();
    chk("rpc_lat_n2", 576'(rpc_out_valid), 576'(1));
    mmio_write(16'h0FF, {4{rand128()}}, 1'b0, 0);
    mmio_write(16'h140, {4{rand128()}}, 1'b0, 0);
    drain("mmio_a", 10);
    chk("rx_drop_window", 576'(stat_rx_drop), 576'(exp_stat(2)));
    number_of_flows = L'(3);
    mmio_write(16'h130, {4{rand128()}}, 1'b0, 0);
    mmio_write(16'h110, {4{rand128()}}, 1'b1, 1);
    mmio_write(16'h10F, {4{rand128()}}, 1'b1, 0);
    drain("mmio_b", 10);
    chk("rx_drop_flow", 576'(stat_rx_drop), 576'(exp_stat(3)));

    // First write latency, then ring wrap on flow 1 (ends with tail[1]=3)
    rpc_push(0, rand128(), 1'b1);
    chk("c1_lat_n1", 576'(sTx_c1.valid), 576'(0));
    tick();
    chk("c1_lat_n2", 576'(sTx_c1.valid), 576'(1));
    for (int i = 0; i < 7; i++) rpc_push(1, rand128(), 1'b1);
    drain("wrap", 20);

    // Re-initialize clears the tails
    run_init("init2");
    rpc_push(1, rand128(), 1'b1);
    rpc_push(0, rand128(), 1'b1);
    drain("post_clear", 10);

    // Backpressure: 20 pushes into 16 entries while c1 is almost full
    sRx_c1TxAlmFull = 1'b1;
    seen0 = c1_seen;
    for (int i = 0; i < 20; i++) begin
      rpc_push(i % 4, rand128(), i < 16);
      if (i == 12) chk("bp_ready_13", 576'(ccip_tx_ready), 576'(1));
      if (i == 14) chk("bp_ready_15", 576'(ccip_tx_ready), 576'(0));
    end
    tick();
    chk("bp_no_write", 576'(c1_seen - seen0), 576'(0));
    chk("tx_ovf", 576'(stat_tx_ovf), 576'(exp_stat(4)));
    sRx_c1TxAlmFull = 1'b0;
    drain("bp", 60);
    chk("bp_writes", 576'(c1_seen - seen0), 576'(16));

    // Re-initialize with 3 entries queued: they must vanish
    sRx_c1TxAlmFull = 1'b1;
    for (int i = 0; i < 3; i++) rpc_push(2, rand128(), 1'b0);
    chk("flush_pre_init", 576'(initialized), 576'(1));
    seen0 = c1_seen;
    run_init("init3");
    sRx_c1TxAlmFull = 1'b0;
    repeat (10) tick();
    chk("flush_no_write", 576'(c1_seen - seen0), 576'(0));

    // start=0 silences both paths
    start = 1'b0;
    seen0 = c1_seen + rpc_seen;
    mmio_write(16'h110, {4{rand128()}}, 1'b0, 0);
    rpc_push(1, rand128(), 1'b0);
    repeat (8) tick();
    chk("stopped_outputs", 576'(c1_seen + rpc_seen - seen0), 576'(0));
    chk("stopped_rx_drop", 576'(stat_rx_drop), 576'(exp_stat(3)));

    chk("final_queues", 576'(exp_q.size() + exp_rpc_q.size()), 576'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
